ro_entropy_collector: RTL and testbench

Parametrised ring-oscillator entropy source: NUM_RINGS free-running inverter rings of RING_LEN stages each. The rings are sampled into the clk domain, XOR-combined into one raw bit, and decimated by SAMPLE_DIV. The bits are packed into WORD_WIDTH-bit words and delivered over a valid/ack handshake. It sits between the raw oscillator primitives and the entropy mixer/conditioner, replacing single fixed-length ring instances.

---
 rtl/ro_entropy_collector.sv | 217 +++++++++++++++++++++
 tb/tb_ro_entropy_collector.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ro_entropy_collector.sv
// Ring-oscillator entropy collector: NUM_RINGS free-running inverter rings are
// synchronised, XOR-combined into raw_bit, decimated by SAMPLE_DIV and packed
// into WORD_WIDTH-bit words delivered over a valid/ack handshake.
//
// Latency : ring -> raw_bit 3 clk; enable registered -> entropy_valid
//           WORD_WIDTH*SAMPLE_DIV clk later (WORD_WIDTH*SAMPLE_DIV+1 counting
//           the edge that registers enable); ack -> next word likewise.
// Backpressure: while entropy_valid=1 sampling is paused and counters are
//           frozen until entropy_ack; entropy_data stays stable meanwhile.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable            runs rings and collection; low forces rings static
//   test_mode/test_bit deterministic raw bit replaces the ring bit
//   entropy_data/_valid/_ack  word handshake
//   raw_bit           registered XOR of synchronised ring taps (debug)
//   health_error      sticky repetition-count failure
//
// Optional feature: define RO_ENTROPY_REPEAT_TEST_EN to build the
// repetition-count health test; otherwise health_error is tied low.

module ro_entropy_collector #(
    parameter int NUM_RINGS  = 8,
    parameter int RING_LEN   = 41,
    parameter int SAMPLE_DIV = 16,
    parameter int WORD_WIDTH = 32,
    parameter int REP_LIMIT  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  test_mode,
    input  logic                  test_bit,
    output logic [WORD_WIDTH-1:0] entropy_data,
    output logic                  entropy_valid,
    input  logic                  entropy_ack,
    output logic                  raw_bit,
    output logic                  health_error
);

    // ------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------
    if ((RING_LEN % 2) == 0 || RING_LEN < 3) begin : g_bad_ring_len
        $error("ro_entropy_collector: RING_LEN must be odd and >= 3");
    end
    if (NUM_RINGS < 1 || SAMPLE_DIV < 2 || WORD_WIDTH < 2 || REP_LIMIT < 2) begin : g_bad_param
        $error("ro_entropy_collector: parameter below its minimum");
    end

    localparam int SC_W = $clog2(SAMPLE_DIV);
    localparam int BC_W = $clog2(WORD_WIDTH + 1);

    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SAMPLE_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_WIDTH - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COLLECT  = 2'd1;
    localparam logic [1:0] S_WAIT_ACK = 2'd2;

    // ------------------------------------------------------------------
    // Rings. Test mode also holds the rings static so bring-up runs are
    // fully deterministic and free of oscillator noise coupling.
    // ------------------------------------------------------------------
    logic                 ring_en;
    logic [NUM_RINGS-1:0] ring_tap;

    assign ring_en = enable & ~test_mode;

    for (genvar r = 0; r < NUM_RINGS; r++) begin : g_ring
        (* keep = "true", dont_touch = "true" *) logic [RING_LEN-1:0] node;

        // NAND head: with ring_en low the head is forced to 1 and every
        // following inverter settles, so the ring is static.
        assign node[0] = ~(ring_en & node[RING_LEN-1]);

        for (genvar k = 1; k < RING_LEN; k++) begin : g_inv
            assign node[k] = ~node[k-1];
        end

        assign ring_tap[r] = node[0];
    end

    // ------------------------------------------------------------------
    // Two-flop synchronisers per tap, then a registered XOR combine.
    // ------------------------------------------------------------------
    logic [NUM_RINGS-1:0] sync_a;
    logic [NUM_RINGS-1:0] sync_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a  <= '0;
            sync_b  <= '0;
            raw_bit <= 1'b0;
        end else begin
            sync_a  <= ring_tap;
            sync_b  <= sync_a;
            raw_bit <= ^sync_b;
        end
    end

    // ------------------------------------------------------------------
    // Collection FSM
    // ------------------------------------------------------------------
    logic [1:0]            state;
    logic [SC_W-1:0]       sample_ctr;
    logic [BC_W-1:0]       bit_ctr;
    logic [WORD_WIDTH-2:0] shift_q;
    logic                  sample_bit;
    logic                  sample_stb;
    logic [WORD_WIDTH-1:0] shift_next;

    assign sample_bit = test_mode ? test_bit : raw_bit;
    assign sample_stb = enable && (state == S_COLLECT) && (sample_ctr == SC_LAST);
    // Word as it looks once the current sample is appended; the oldest
    // sample ends up in the MSB.
    assign shift_next = {shift_q, sample_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            sample_ctr    <= '0;
            bit_ctr       <= '0;
            shift_q       <= '0;
            entropy_data  <= '0;
            entropy_valid <= 1'b0;
        end else if (!enable) begin
            // Dropping enable abandons any partial word; the last delivered
            // word stays readable on entropy_data.
            state         <= S_IDLE;
            sample_ctr    <= '0;
            bit_ctr       <= '0;
            shift_q       <= '0;
            entropy_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state      <= S_COLLECT;
                    sample_ctr <= '0;
                    bit_ctr    <= '0;
                end
                S_COLLECT: begin
                    if (sample_ctr == SC_LAST) begin
                        sample_ctr <= '0;
                        shift_q    <= shift_next[WORD_WIDTH-2:0];
                        bit_ctr    <= bit_ctr + 1'b1;
                        if (bit_ctr == BC_LAST) begin
                            entropy_data  <= shift_next;
                            entropy_valid <= 1'b1;
                            state         <= S_WAIT_ACK;
                        end
                    end else begin
                        sample_ctr <= sample_ctr + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    // Counters hold (bit_ctr == WORD_WIDTH) until the
                    // consumer takes the word.
                    if (entropy_ack) begin
                        entropy_valid <= 1'b0;
                        sample_ctr    <= '0;
                        bit_ctr       <= '0;
                        state         <= S_COLLECT;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    sample_ctr    <= '0;
                    bit_ctr       <= '0;
                    entropy_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Repetition-count health test
    // ------------------------------------------------------------------
`ifdef RO_ENTROPY_REPEAT_TEST_EN
    localparam int RC_W = $clog2(REP_LIMIT + 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(REP_LIMIT);

    logic [RC_W-1:0] rep_ctr;
    logic            rep_last;
    logic            health_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_ctr  <= '0;
            rep_last <= 1'b0;
            health_q <= 1'b0;
        end else if (!enable) begin
            // Run length restarts with the next collection; the failure
            // flag is sticky until reset.
            rep_ctr <= '0;
        end else if (sample_stb) begin
            rep_last <= sample_bit;
            // rep_ctr == 0 means no previous sample to compare against.
            if (rep_ctr != '0 && sample_bit == rep_last) begin
                if (rep_ctr != RC_MAX) begin
                    rep_ctr <= rep_ctr + 1'b1;
                end
                if (rep_ctr == RC_MAX - 1'b1) begin
                    health_q <= 1'b1;
                end
            end else begin
                rep_ctr <= RC_W'(1);
            end
        end
    end

    assign health_error = health_q;
`else
    assign health_error = 1'b0;
`endif

endmodule

// File: tb/tb_ro_entropy_collector.sv
module tb_ro_entropy_collector;

    localparam int D   = 16;
    localparam int W   = 32;
    localparam int REP = 32;

`ifdef RO_ENTROPY_REPEAT_TEST_EN
    localparam logic HEALTH_ON = 1'b1;
`else
    localparam logic HEALTH_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          test_mode;
    logic          test_bit;
    logic [W-1:0]  entropy_data;
    logic          entropy_valid;
    logic          entropy_ack;
    logic          raw_bit;
    logic          health_error;

    always #5 clk = ~clk;

    ro_entropy_collector #(
        .NUM_RINGS (8),
        .RING_LEN  (41),
        .SAMPLE_DIV(D),
        .WORD_WIDTH(W),
        .REP_LIMIT (REP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .test_mode    (test_mode),
        .test_bit     (test_bit),
        .entropy_data (entropy_data),
        .entropy_valid(entropy_valid),
        .entropy_ack  (entropy_ack),
        .raw_bit      (raw_bit),
        .health_error (health_error)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: counts clock edges since the word began, takes
    // every D-th edge as a sample, and delivers once W samples are queued.
    // ------------------------------------------------------------------
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_health;
    bit           m_active;
    int           m_t;
    bit           m_bits[$];
    int           m_run;
    bit           m_last;
    bit           chk_on = 1'b0;

    always @(posedge clk) begin
        bit b;
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_health = 1'b0;
            m_active = 1'b0; m_t = 0; m_bits.delete(); m_run = 0;
        end else if (!enable) begin
            m_active = 1'b0; m_valid = 1'b0; m_bits.delete(); m_run = 0;
        end else if (!m_active) begin
            m_active = 1'b1; m_t = 0;
        end else if (m_valid) begin
            if (entropy_ack) begin
                m_valid = 1'b0; m_t = 0; m_bits.delete();
            end
        end else begin
            m_t++;
            if (m_t % D == 0) begin
                b = test_mode ? test_bit : raw_bit;
                if (m_run > 0 && b == m_last) m_run++;
                else m_run = 1;
                m_last = b;
                if (HEALTH_ON && m_run == REP) m_health = 1'b1;
                m_bits.push_back(b);
                if (m_bits.size() == W) begin
                    m_data = '0;
                    foreach (m_bits[i]) m_data = {m_data[W-2:0], m_bits[i]};
                    m_valid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_valid",  {31'd0, entropy_valid}, {31'd0, m_valid});
            check("cyc_data",   entropy_data, m_data);
            check("cyc_health", {31'd0, health_error}, {31'd0, m_health});
        end
    end

    // Count negedges until entropy_valid, bounded; prev_h is health one
    // negedge before valid was seen.
    task automatic wait_valid(output int n, output logic prev_h);
        n = 0;
        prev_h = health_error;
        while (n < 700 && !entropy_valid) begin
            prev_h = health_error;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_ack();
        entropy_ack = 1'b1;
        @(negedge clk);
        entropy_ack = 1'b0;
    endtask

    initial begin
        int   n;
        logic ph;
        logic pv;

        reset = 1'b1; enable = 1'b0; test_mode = 1'b1; test_bit = 1'b0; entropy_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("rst_valid",  {31'd0, entropy_valid}, 32'd0);
        check("rst_data",   entropy_data, 32'h0);
        check("rst_raw",    {31'd0, raw_bit}, 32'd0);
        check("rst_health", {31'd0, health_error}, 32'd0);

        reset = 1'b0;
        repeat (1000) @(negedge clk);
        check("idle_valid", {31'd0, entropy_valid}, 32'd0);
        check("idle_raw",   {31'd0, raw_bit}, 32'd0);

        // Constant ones
        test_bit = 1'b1;
        enable   = 1'b1;
        wait_valid(n, ph);
        check("ones_latency", n, 513);
        check("ones_data", entropy_data, 32'hFFFF_FFFF);
        check("ones_health", {31'd0, health_error}, {31'd0, HEALTH_ON});
        check("ones_health_before", {31'd0, ph}, 32'd0);
        repeat (50) @(negedge clk);
        check("hold_valid", {31'd0, entropy_valid}, 32'd1);
        check("hold_data", entropy_data, 32'hFFFF_FFFF);

        // Alternating bits, starting at 1, word started by the ack edge
        pulse_ack();
        check("ack_drop", {31'd0, entropy_valid}, 32'd0);
        pv = 1'b0;
        for (int k = 0; k < W; k++) begin
            test_bit = (k % 2 == 0);
            repeat (D - 1) @(negedge clk);
            if (k == W - 1) pv = entropy_valid;
            @(negedge clk);
        end
        check("alt_valid_early", {31'd0, pv}, 32'd0);
        check("alt_valid", {31'd0, entropy_valid}, 32'd1);
        check("alt_data", entropy_data, 32'hAAAA_AAAA);

        // Drop enable after 20 samples, then re-enable for a fresh word
        pulse_ack();
        test_bit = 1'b1;
        repeat (20 * D) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_valid", {31'd0, entropy_valid}, 32'd0);
        check("abort_data_kept", entropy_data, 32'hAAAA_AAAA);
        check("abort_raw", {31'd0, raw_bit}, 32'd0);
        test_bit = 1'b0;
        enable   = 1'b1;
        wait_valid(n, ph);
        check("reen_latency", n, 513);
        check("reen_data", entropy_data, 32'h0);
        check("reen_health_sticky", {31'd0, health_error}, {31'd0, HEALTH_ON});

        // Reset in the middle of a word
        pulse_ack();
        test_bit = 1'b1;
        repeat (5 * D) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_valid",  {31'd0, entropy_valid}, 32'd0);
        check("midrst_data",   entropy_data, 32'h0);
        check("midrst_health", {31'd0, health_error}, 32'd0);
        repeat (100) @(negedge clk);
        check("midrst_no_word", {31'd0, entropy_valid}, 32'd0);
        enable = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
